// File: rtl/rtl_pkg.sv
// Shared encodings and packet types for the decode stage feeding the bit-manipulation unit.
package rtl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_SH1ADD = 3'b010;
  localparam logic [2:0] F3_SH2ADD = 3'b100;
  localparam logic [2:0] F3_SH3ADD = 3'b110;
  localparam logic [2:0] F3_MIN    = 3'b100;
  localparam logic [2:0] F3_MINU   = 3'b101;
  localparam logic [2:0] F3_MAX    = 3'b110;
  localparam logic [2:0] F3_MAXU   = 3'b111;
  localparam logic [2:0] F3_PACK   = 3'b100;
  localparam logic [2:0] F3_PACKH  = 3'b111;
  localparam logic [2:0] F3_ROL    = 3'b001;
  localparam logic [2:0] F3_ROR    = 3'b101;
  localparam logic [2:0] F3_BSET   = 3'b001;
  localparam logic [2:0] F3_BEXT   = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_ZBA    = 7'b0010000;
  localparam logic [6:0] F7_MINMAX = 7'b0000101;
  localparam logic [6:0] F7_PACK   = 7'b0000100;
  localparam logic [6:0] F7_ROT    = 7'b0110000;
  localparam logic [6:0] F7_BSET   = 7'b0010100;
  localparam logic [6:0] F7_BCLR   = 7'b0100100;
  localparam logic [6:0] F7_BINV   = 7'b0110100;

  // Unary Zbb ops share funct7 0110000 / funct3 001 and are told apart by the rs2 field.
  localparam logic [4:0] U_CLZ   = 5'b00000;
  localparam logic [4:0] U_CTZ   = 5'b00001;
  localparam logic [4:0] U_CPOP  = 5'b00010;
  localparam logic [4:0] U_SEXTB = 5'b00100;
  localparam logic [4:0] U_SEXTH = 5'b00101;

  localparam logic [11:0] F12_REV8 = 12'h698;
  localparam logic [11:0] F12_ORCB = 12'h287;

  typedef struct packed {
    logic valid;
    logic land, lor, lxor;
    logic sll, srl, sra, slt, unsign;
    logic add, sub;
    logic zbb, zba, sh1add, sh2add, sh3add;
    logic clz, ctz, cpop, sext_b, sext_h;
    logic min, max, rol, ror, grev, gorc, pack, packh;
    logic bset, bclr, binv, bext;
  } rtl_alu_pkt_t;

  typedef enum logic [1:0] {B_RS2, B_IMM, B_SHAMT} b_sel_t;

  typedef struct packed {
    rtl_alu_pkt_t ap;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         illegal;
  } stage_entry_t;

endpackage

// File: rtl/bmu_decode_stage_if.sv
// Upstream instruction handshake and execute-side result bus of the decode stage.
interface bmu_decode_stage_if;
  import rtl_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [31:0]  in_rs1;
  logic [31:0]  in_rs2;
  logic         out_valid;
  logic         out_stall;
  rtl_alu_pkt_t out_ap;
  logic [31:0]  out_a;
  logic [31:0]  out_b;
  logic         out_illegal;

  modport master (output in_valid, in_instr, in_rs1, in_rs2, out_stall,
                  input  in_ready, out_valid, out_ap, out_a, out_b, out_illegal);
  modport slave  (input  in_valid, in_instr, in_rs1, in_rs2, out_stall,
                  output in_ready, out_valid, out_ap, out_a, out_b, out_illegal);
endinterface

// File: rtl/bmu_decoder.sv
// Combinational RV32 base/Zba/Zbb/Zbs decoder producing the ALU predecode packet and B-operand select.
module bmu_decoder
  import rtl_pkg::*;
#(
  parameter int BITMANIP_ZBA = 1,
  parameter int BITMANIP_ZBB = 1,
  parameter int BITMANIP_ZBS = 1
) (
  input  logic [31:0]  instr,
  output rtl_alu_pkt_t ap,
  output b_sel_t       b_sel,
  output logic [31:0]  imm,
  output logic         illegal
);
  localparam bit ZBA_ON = (BITMANIP_ZBA != 0);
  localparam bit ZBB_ON = (BITMANIP_ZBB != 0);
  localparam bit ZBS_ON = (BITMANIP_ZBS != 0);

  logic [6:0]   opcode, funct7;
  logic [2:0]   funct3;
  logic [4:0]   rs2_f;
  logic [11:0]  funct12;
  logic         legal;
  rtl_alu_pkt_t p;
  logic         unused_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign rs2_f     = instr[24:20];
  assign funct12   = instr[31:20];
  assign unused_rd = &{1'b0, instr[19:7]};

  always_comb begin
    p     = '0;
    legal = 1'b0;
    b_sel = B_RS2;
    imm   = {{20{instr[31]}}, instr[31:20]};
    if (opcode == OP) begin
      case ({funct7, funct3})
        {F7_BASE, F3_ADD}:     begin p.add = 1'b1; legal = 1'b1; end
        {F7_ALT,  F3_ADD}:     begin p.sub = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_SLL}:     begin p.sll = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_SLT}:     begin p.slt = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_SLTU}:    begin p.slt = 1'b1; p.unsign = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_XOR}:     begin p.lxor = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_SR}:      begin p.srl = 1'b1; legal = 1'b1; end
        {F7_ALT,  F3_SR}:      begin p.sra = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_OR}:      begin p.lor = 1'b1; legal = 1'b1; end
        {F7_BASE, F3_AND}:     begin p.land = 1'b1; legal = 1'b1; end
        {F7_ALT,  F3_AND}:     if (ZBB_ON) begin p.land = 1'b1; p.zbb = 1'b1; legal = 1'b1; end
        {F7_ALT,  F3_OR}:      if (ZBB_ON) begin p.lor  = 1'b1; p.zbb = 1'b1; legal = 1'b1; end
        {F7_ALT,  F3_XOR}:     if (ZBB_ON) begin p.lxor = 1'b1; p.zbb = 1'b1; legal = 1'b1; end
        {F7_MINMAX, F3_MIN}:   if (ZBB_ON) begin p.min = 1'b1; legal = 1'b1; end
        {F7_MINMAX, F3_MINU}:  if (ZBB_ON) begin p.min = 1'b1; p.unsign = 1'b1; legal = 1'b1; end
        {F7_MINMAX, F3_MAX}:   if (ZBB_ON) begin p.max = 1'b1; legal = 1'b1; end
        {F7_MINMAX, F3_MAXU}:  if (ZBB_ON) begin p.max = 1'b1; p.unsign = 1'b1; legal = 1'b1; end
        {F7_ROT,  F3_ROL}:     if (ZBB_ON) begin p.rol = 1'b1; legal = 1'b1; end
        {F7_ROT,  F3_ROR}:     if (ZBB_ON) begin p.ror = 1'b1; legal = 1'b1; end
        {F7_PACK, F3_PACK}:    if (ZBB_ON) begin p.pack = 1'b1; legal = 1'b1; end
        {F7_PACK, F3_PACKH}:   if (ZBB_ON) begin p.packh = 1'b1; legal = 1'b1; end
        {F7_ZBA,  F3_SH1ADD}:  if (ZBA_ON) begin p.add = 1'b1; p.zba = 1'b1; p.sh1add = 1'b1; legal = 1'b1; end
        {F7_ZBA,  F3_SH2ADD}:  if (ZBA_ON) begin p.add = 1'b1; p.zba = 1'b1; p.sh2add = 1'b1; legal = 1'b1; end
        {F7_ZBA,  F3_SH3ADD}:  if (ZBA_ON) begin p.add = 1'b1; p.zba = 1'b1; p.sh3add = 1'b1; legal = 1'b1; end
        {F7_BSET, F3_BSET}:    if (ZBS_ON) begin p.bset = 1'b1; legal = 1'b1; end
        {F7_BCLR, F3_BSET}:    if (ZBS_ON) begin p.bclr = 1'b1; legal = 1'b1; end
        {F7_BINV, F3_BSET}:    if (ZBS_ON) begin p.binv = 1'b1; legal = 1'b1; end
        {F7_BCLR, F3_BEXT}:    if (ZBS_ON) begin p.bext = 1'b1; legal = 1'b1; end
        default: ;
      endcase
    end else if (opcode == OP_IMM) begin
      b_sel = B_IMM;
      case (funct3)
        F3_ADD:  begin p.add = 1'b1; legal = 1'b1; end
        F3_SLT:  begin p.slt = 1'b1; legal = 1'b1; end
        F3_SLTU: begin p.slt = 1'b1; p.unsign = 1'b1; legal = 1'b1; end
        F3_XOR:  begin p.lxor = 1'b1; legal = 1'b1; end
        F3_OR:   begin p.lor = 1'b1; legal = 1'b1; end
        F3_AND:  begin p.land = 1'b1; legal = 1'b1; end
        F3_SLL: begin
          b_sel = B_SHAMT;
          case (funct7)
            F7_BASE: begin p.sll = 1'b1; legal = 1'b1; end
            F7_ROT: if (ZBB_ON) begin
              legal = 1'b1;
              case (rs2_f)
                U_CLZ:   p.clz    = 1'b1;
                U_CTZ:   p.ctz    = 1'b1;
                U_CPOP:  p.cpop   = 1'b1;
                U_SEXTB: p.sext_b = 1'b1;
                U_SEXTH: p.sext_h = 1'b1;
                default: legal    = 1'b0;
              endcase
            end
            F7_BSET: if (ZBS_ON) begin p.bset = 1'b1; legal = 1'b1; end
            F7_BCLR: if (ZBS_ON) begin p.bclr = 1'b1; legal = 1'b1; end
            F7_BINV: if (ZBS_ON) begin p.binv = 1'b1; legal = 1'b1; end
            default: ;
          endcase
        end
        F3_SR: begin
          b_sel = B_SHAMT;
          // rev8/orc.b are byte-granular grev/gorc with a fixed control word on B.
          if (funct12 == F12_REV8) begin
            if (ZBB_ON) begin p.grev = 1'b1; legal = 1'b1; b_sel = B_IMM; imm = 32'h18; end
          end else if (funct12 == F12_ORCB) begin
            if (ZBB_ON) begin p.gorc = 1'b1; legal = 1'b1; b_sel = B_IMM; imm = 32'h07; end
          end else begin
            case (funct7)
              F7_BASE: begin p.srl = 1'b1; legal = 1'b1; end
              F7_ALT:  begin p.sra = 1'b1; legal = 1'b1; end
              F7_ROT:  if (ZBB_ON) begin p.ror = 1'b1; legal = 1'b1; end
              F7_BCLR: if (ZBS_ON) begin p.bext = 1'b1; legal = 1'b1; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
    ap = '0;
    if (legal) begin
      ap       = p;
      ap.valid = 1'b1;
    end
    illegal = ~legal;
  end
endmodule

// File: rtl/bmu_decode_stage.sv
// Decode/operand stage: decodes one instruction per cycle and hands it to execute via an output register plus skid slot.
//
// state ({out_valid, skid_valid}) | meaning
// EMPTY 00 | nothing held, ready
// ONE   10 | output register holds the oldest entry, ready
// FULL  11 | output and skid both hold entries, not ready
module bmu_decode_stage
  import rtl_pkg::*;
#(
  parameter int BITMANIP_ZBA = 1,
  parameter int BITMANIP_ZBB = 1,
  parameter int BITMANIP_ZBS = 1
) (
  input logic               clk,
  input logic               rst_l,
  input logic               flush,
  bmu_decode_stage_if.slave bus
);
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  rtl_alu_pkt_t dec_ap;
  b_sel_t       dec_b_sel;
  logic [31:0]  dec_imm;
  logic         dec_illegal;
  stage_entry_t new_e, out_q, skid_q;
  logic         out_valid_q, skid_valid_q;
  logic         accept, stall;
  logic [1:0]   state;

  bmu_decoder #(
    .BITMANIP_ZBA(BITMANIP_ZBA),
    .BITMANIP_ZBB(BITMANIP_ZBB),
    .BITMANIP_ZBS(BITMANIP_ZBS)
  ) u_dec (
    .instr  (bus.in_instr),
    .ap     (dec_ap),
    .b_sel  (dec_b_sel),
    .imm    (dec_imm),
    .illegal(dec_illegal)
  );

  // Illegal entries carry no operands so execute sees a clean all-zero payload.
  always_comb begin
    new_e         = '0;
    new_e.illegal = dec_illegal;
    if (!dec_illegal) begin
      new_e.ap = dec_ap;
      new_e.a  = bus.in_rs1;
      case (dec_b_sel)
        B_RS2:   new_e.b = bus.in_rs2;
        B_SHAMT: new_e.b = {27'b0, bus.in_instr[24:20]};
        default: new_e.b = dec_imm;
      endcase
    end
  end

  assign accept = bus.in_valid & ~skid_valid_q;
  assign stall  = bus.out_stall;
  assign state  = {out_valid_q, skid_valid_q};

  always_ff @(posedge clk) begin
    if (rst_l || flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          out_q       <= new_e;
          out_valid_q <= 1'b1;
        end
        ST_ONE: begin
          if (accept && !stall) begin
            out_q <= new_e;
          end else if (accept && stall) begin
            skid_q       <= new_e;
            skid_valid_q <= 1'b1;
          end else if (!stall) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: if (!stall) begin
          out_q        <= skid_q;
          skid_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = ~skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_ap      = out_q.ap;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_bmu_decode_stage.sv
// Bench for bmu_decode_stage: directed cases plus random traffic against a mask/match decode table and a queue model.
module tb_bmu_decode_stage;
  import rtl_pkg::*;

  typedef struct {
    logic [31:0]  mask;
    logic [31:0]  match;
    int           ext;   // 0 base, 1 zba, 2 zbb, 3 zbs
    rtl_alu_pkt_t ap;
    int           bk;    // 0 rs2, 1 imm, 2 shamt, 3 const
    logic [31:0]  cval;
  } op_t;

  logic clk, rst_l, flush;
  int   total, bad;
  op_t  ops[$];
  stage_entry_t q[$];
  stage_entry_t q0[$];

  bmu_decode_stage_if if1();
  bmu_decode_stage_if if0();

  assign if0.in_valid  = if1.in_valid;
  assign if0.in_instr  = if1.in_instr;
  assign if0.in_rs1    = if1.in_rs1;
  assign if0.in_rs2    = if1.in_rs2;
  assign if0.out_stall = if1.out_stall;

  bmu_decode_stage #(.BITMANIP_ZBA(1), .BITMANIP_ZBB(1), .BITMANIP_ZBS(1)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush), .bus(if1));
  bmu_decode_stage #(.BITMANIP_ZBA(0), .BITMANIP_ZBB(1), .BITMANIP_ZBS(1)) dut0 (
    .clk(clk), .rst_l(rst_l), .flush(flush), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(logic [11:0] hi, logic [2:0] f3, logic [6:0] opc);
    return {hi, 5'b0, f3, 5'b0, opc};
  endfunction
  function automatic logic [31:0] fr(logic [6:0] f7, logic [2:0] f3);
    return enc({f7, 5'b0}, f3, 7'h33);
  endfunction
  function automatic logic [31:0] fs(logic [6:0] f7, logic [2:0] f3);
    return enc({f7, 5'b0}, f3, 7'h13);
  endfunction

  task automatic add_op(input logic [31:0] mask, input logic [31:0] match, input int ext,
                        input rtl_alu_pkt_t ap, input int bk, input logic [31:0] cval);
    op_t o;
    o.mask = mask; o.match = match; o.ext = ext; o.ap = ap; o.bk = bk; o.cval = cval;
    ops.push_back(o);
  endtask

  task automatic build_ops();
    rtl_alu_pkt_t p;
    logic [31:0] mr, mi, mu;
    mr = 32'hFE00707F; mi = 32'h0000707F; mu = 32'hFFF0707F;
    p = '0; p.add = 1;              add_op(mr, fr(7'h00, 3'd0), 0, p, 0, 0);
    p = '0; p.sub = 1;              add_op(mr, fr(7'h20, 3'd0), 0, p, 0, 0);
    p = '0; p.sll = 1;              add_op(mr, fr(7'h00, 3'd1), 0, p, 0, 0);
    p = '0; p.slt = 1;              add_op(mr, fr(7'h00, 3'd2), 0, p, 0, 0);
    p = '0; p.slt = 1; p.unsign = 1; add_op(mr, fr(7'h00, 3'd3), 0, p, 0, 0);
    p = '0; p.lxor = 1;             add_op(mr, fr(7'h00, 3'd4), 0, p, 0, 0);
    p = '0; p.srl = 1;              add_op(mr, fr(7'h00, 3'd5), 0, p, 0, 0);
    p = '0; p.sra = 1;              add_op(mr, fr(7'h20, 3'd5), 0, p, 0, 0);
    p = '0; p.lor = 1;              add_op(mr, fr(7'h00, 3'd6), 0, p, 0, 0);
    p = '0; p.land = 1;             add_op(mr, fr(7'h00, 3'd7), 0, p, 0, 0);
    p = '0; p.land = 1; p.zbb = 1;  add_op(mr, fr(7'h20, 3'd7), 2, p, 0, 0);
    p = '0; p.lor = 1; p.zbb = 1;   add_op(mr, fr(7'h20, 3'd6), 2, p, 0, 0);
    p = '0; p.lxor = 1; p.zbb = 1;  add_op(mr, fr(7'h20, 3'd4), 2, p, 0, 0);
    p = '0; p.min = 1;              add_op(mr, fr(7'h05, 3'd4), 2, p, 0, 0);
    p = '0; p.min = 1; p.unsign = 1; add_op(mr, fr(7'h05, 3'd5), 2, p, 0, 0);
    p = '0; p.max = 1;              add_op(mr, fr(7'h05, 3'd6), 2, p, 0, 0);
    p = '0; p.max = 1; p.unsign = 1; add_op(mr, fr(7'h05, 3'd7), 2, p, 0, 0);
    p = '0; p.rol = 1;              add_op(mr, fr(7'h30, 3'd1), 2, p, 0, 0);
    p = '0; p.ror = 1;              add_op(mr, fr(7'h30, 3'd5), 2, p, 0, 0);
    p = '0; p.pack = 1;             add_op(mr, fr(7'h04, 3'd4), 2, p, 0, 0);
    p = '0; p.packh = 1;            add_op(mr, fr(7'h04, 3'd7), 2, p, 0, 0);
    p = '0; p.add = 1; p.zba = 1; p.sh1add = 1; add_op(mr, fr(7'h10, 3'd2), 1, p, 0, 0);
    p = '0; p.add = 1; p.zba = 1; p.sh2add = 1; add_op(mr, fr(7'h10, 3'd4), 1, p, 0, 0);
    p = '0; p.add = 1; p.zba = 1; p.sh3add = 1; add_op(mr, fr(7'h10, 3'd6), 1, p, 0, 0);
    p = '0; p.bset = 1;             add_op(mr, fr(7'h14, 3'd1), 3, p, 0, 0);
    p = '0; p.bclr = 1;             add_op(mr, fr(7'h24, 3'd1), 3, p, 0, 0);
    p = '0; p.binv = 1;             add_op(mr, fr(7'h34, 3'd1), 3, p, 0, 0);
    p = '0; p.bext = 1;             add_op(mr, fr(7'h24, 3'd5), 3, p, 0, 0);
    p = '0; p.add = 1;              add_op(mi, fs(7'h00, 3'd0), 0, p, 1, 0);
    p = '0; p.slt = 1;              add_op(mi, fs(7'h00, 3'd2), 0, p, 1, 0);
    p = '0; p.slt = 1; p.unsign = 1; add_op(mi, fs(7'h00, 3'd3), 0, p, 1, 0);
    p = '0; p.lxor = 1;             add_op(mi, fs(7'h00, 3'd4), 0, p, 1, 0);
    p = '0; p.lor = 1;              add_op(mi, fs(7'h00, 3'd6), 0, p, 1, 0);
    p = '0; p.land = 1;             add_op(mi, fs(7'h00, 3'd7), 0, p, 1, 0);
    p = '0; p.sll = 1;              add_op(mr, fs(7'h00, 3'd1), 0, p, 2, 0);
    p = '0; p.srl = 1;              add_op(mr, fs(7'h00, 3'd5), 0, p, 2, 0);
    p = '0; p.sra = 1;              add_op(mr, fs(7'h20, 3'd5), 0, p, 2, 0);
    p = '0; p.ror = 1;              add_op(mr, fs(7'h30, 3'd5), 2, p, 2, 0);
    p = '0; p.bset = 1;             add_op(mr, fs(7'h14, 3'd1), 3, p, 2, 0);
    p = '0; p.bclr = 1;             add_op(mr, fs(7'h24, 3'd1), 3, p, 2, 0);
    p = '0; p.binv = 1;             add_op(mr, fs(7'h34, 3'd1), 3, p, 2, 0);
    p = '0; p.bext = 1;             add_op(mr, fs(7'h24, 3'd5), 3, p, 2, 0);
    p = '0; p.clz = 1;              add_op(mu, enc(12'h600, 3'd1, 7'h13), 2, p, 2, 0);
    p = '0; p.ctz = 1;              add_op(mu, enc(12'h601, 3'd1, 7'h13), 2, p, 2, 0);
    p = '0; p.cpop = 1;             add_op(mu, enc(12'h602, 3'd1, 7'h13), 2, p, 2, 0);
    p = '0; p.sext_b = 1;           add_op(mu, enc(12'h604, 3'd1, 7'h13), 2, p, 2, 0);
    p = '0; p.sext_h = 1;           add_op(mu, enc(12'h605, 3'd1, 7'h13), 2, p, 2, 0);
    p = '0; p.grev = 1;             add_op(mu, enc(12'h698, 3'd5, 7'h13), 2, p, 3, 32'h18);
    p = '0; p.gorc = 1;             add_op(mu, enc(12'h287, 3'd5, 7'h13), 2, p, 3, 32'h07);
  endtask

  function automatic stage_entry_t model(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2, bit zba_en);
    stage_entry_t e;
    e = '0;
    e.illegal = 1'b1;
    foreach (ops[k]) begin
      if (((instr & ops[k].mask) == ops[k].match) && (ops[k].ext != 1 || zba_en)) begin
        e.illegal  = 1'b0;
        e.ap       = ops[k].ap;
        e.ap.valid = 1'b1;
        e.a        = rs1;
        case (ops[k].bk)
          0:       e.b = rs2;
          1:       e.b = {{20{instr[31]}}, instr[31:20]};
          2:       e.b = {27'b0, instr[24:20]};
          default: e.b = ops[k].cval;
        endcase
      end
    end
    return e;
  endfunction

  task automatic compare();
    chk("in_ready",   64'(if1.in_ready),  64'(q.size() < 2));
    chk("out_valid",  64'(if1.out_valid), 64'(q.size() > 0));
    chk("in_ready0",  64'(if0.in_ready),  64'(q0.size() < 2));
    chk("out_valid0", 64'(if0.out_valid), 64'(q0.size() > 0));
    if (q.size() > 0) begin
      chk("out_ap",       64'(if1.out_ap),      64'(q[0].ap));
      chk("out_a",        64'(if1.out_a),       64'(q[0].a));
      chk("out_b",        64'(if1.out_b),       64'(q[0].b));
      chk("out_illegal",  64'(if1.out_illegal), 64'(q[0].illegal));
      chk("out_ap0",      64'(if0.out_ap),      64'(q0[0].ap));
      chk("out_b0",       64'(if0.out_b),       64'(q0[0].b));
      chk("out_illegal0", 64'(if0.out_illegal), 64'(q0[0].illegal));
    end
  endtask

  // Drives one cycle at the negedge, advances the queue model at the posedge, checks at the next negedge.
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                     input bit st, input bit fl, input bit rs);
    bit acc, pop;
    stage_entry_t e1, e0;
    if1.in_valid = v; if1.in_instr = ins; if1.in_rs1 = r1; if1.in_rs2 = r2;
    if1.out_stall = st; flush = fl; rst_l = rs;
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && !st;
    e1 = model(ins, r1, r2, 1'b1);
    e0 = model(ins, r1, r2, 1'b0);
    @(posedge clk);
    if (rs || fl) begin
      q.delete(); q0.delete();
    end else begin
      if (pop) begin void'(q.pop_front()); void'(q0.pop_front()); end
      if (acc) begin q.push_back(e1); q0.push_back(e0); end
    end
    @(negedge clk);
    compare();
  endtask

  localparam logic [31:0] I_ANDN  = 32'h40C5F533;
  localparam logic [31:0] I_REV8  = 32'h6985D513;
  localparam logic [31:0] I_ORCB  = 32'h2875D513;
  localparam logic [31:0] I_SH2   = 32'h20C5C533;
  localparam logic [31:0] I_ADDI  = 32'hFFF58513;
  localparam logic [31:0] I_UNK   = 32'h0000007F;

  initial begin
    total = 0; bad = 0;
    build_ops();
    if1.in_valid = 0; if1.in_instr = 0; if1.in_rs1 = 0; if1.in_rs2 = 0; if1.out_stall = 0;
    flush = 0; rst_l = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_ap",      64'(if1.out_ap),      64'(0));
    chk("rst_a",       64'(if1.out_a),       64'(0));
    chk("rst_b",       64'(if1.out_b),       64'(0));
    chk("rst_illegal", 64'(if1.out_illegal), 64'(0));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", 64'(if1.in_ready), 64'(1));

    cyc(1, I_ANDN, 32'hF0F0_FFFF, 32'h0000_FF00, 0, 0, 0);
    chk("andn_valid", 64'(if1.out_valid),   64'(1));
    chk("andn_land",  64'(if1.out_ap.land), 64'(1));
    chk("andn_zbb",   64'(if1.out_ap.zbb),  64'(1));
    chk("andn_a",     64'(if1.out_a),       64'(32'hF0F0_FFFF));
    chk("andn_b",     64'(if1.out_b),       64'(32'h0000_FF00));
    chk("andn_ill",   64'(if1.out_illegal), 64'(0));
    cyc(1, I_REV8, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 0);
    chk("rev8_grev", 64'(if1.out_ap.grev), 64'(1));
    chk("rev8_b",    64'(if1.out_b),       64'(32'h18));
    cyc(1, I_ORCB, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 0);
    chk("orcb_gorc", 64'(if1.out_ap.gorc), 64'(1));
    chk("orcb_b",    64'(if1.out_b),       64'(32'h07));
    cyc(1, I_SH2, 32'h11, 32'h22, 0, 0, 0);
    chk("sh2_nozba_ill", 64'(if0.out_illegal),  64'(1));
    chk("sh2_nozba_ap",  64'(if0.out_ap),       64'(0));
    chk("sh2_add",       64'(if1.out_ap.add),   64'(1));
    chk("sh2_zba",       64'(if1.out_ap.zba),   64'(1));
    chk("sh2_sh2add",    64'(if1.out_ap.sh2add), 64'(1));
    cyc(1, I_ADDI, 32'h5, 32'h6, 0, 0, 0);
    chk("addi_add", 64'(if1.out_ap.add), 64'(1));
    chk("addi_b",   64'(if1.out_b),      64'(32'hFFFF_FFFF));
    cyc(1, I_UNK, 32'h5, 32'h6, 0, 0, 0);
    chk("unk_ill", 64'(if1.out_illegal), 64'(1));
    cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(1, I_ANDN, 32'd1, 32'd0, 1, 0, 0);
    cyc(1, I_ANDN, 32'd2, 32'd0, 1, 0, 0);
    chk("b2b_ready_full", 64'(if1.in_ready), 64'(0));
    cyc(1, I_ANDN, 32'd3, 32'd0, 1, 0, 0);
    chk("b2b_first", 64'(if1.out_a), 64'(1));
    cyc(1, I_ANDN, 32'd3, 32'd0, 0, 0, 0);
    chk("b2b_second", 64'(if1.out_a), 64'(2));
    cyc(1, I_ANDN, 32'd3, 32'd0, 0, 0, 0);
    chk("b2b_third", 64'(if1.out_a), 64'(3));
    cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(1, I_ANDN, 32'd4, 32'd0, 1, 0, 0);
    cyc(1, I_ANDN, 32'd5, 32'd0, 1, 0, 0);
    cyc(1, I_ANDN, 32'd6, 32'd0, 1, 1, 0);
    chk("flush_valid", 64'(if1.out_valid), 64'(0));
    chk("flush_ready", 64'(if1.in_ready),  64'(1));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("flush_gone", 64'(if1.out_valid), 64'(0));

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins, tmp, r1, r2;
      int sel;
      sel = $urandom_range(0, 9);
      tmp = $urandom;
      if (sel < 7) ins = ($urandom & ~ops[$urandom_range(0, ops.size() - 1)].mask);
      else ins = 0;
      if (sel < 7) begin
        int k;
        k = $urandom_range(0, ops.size() - 1);
        ins = (tmp & ~ops[k].mask) | ops[k].match;
      end else if (sel < 9) begin
        ins = {tmp[31:7], (tmp[0] ? 7'h33 : 7'h13)};
      end else begin
        ins = tmp;
      end
      r1 = $urandom; r2 = $urandom;
      cyc($urandom_range(0, 3) != 0, ins, r1, r2, $urandom_range(0, 2) == 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
